systolic_mm_controller: RTL

- Sequencer for an N x N output-stationary systolic array of multiply-accumulate PEs (operands enter west/north edges, products accumulate in place, result exposed per PE).
- On `start`: clears the array, fetches N operand vectors from an external operand buffer, applies diagonal skew, injects zeros outside valid windows, waits for the wavefront to drain, then pulses `done`.
- Sits between the operand buffers and the array edges.

---
 rtl/systolic_mm_controller.sv | 106 ++++++++++
 1 files changed

// File: rtl/systolic_mm_controller.sv
// Sequencer for an N x N output-stationary systolic MAC array: clears the array,
// fetches N operand vectors, skews them onto the west/north edges and waits for drain.
module systolic_mm_controller #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int KW    = $clog2(N)
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [KW-1:0]        rd_k,
  input  logic [N*WIDTH-1:0]   rd_a_col,
  input  logic [N*WIDTH-1:0]   rd_b_row,
  output logic [N*WIDTH-1:0]   a_edge,
  output logic [N*WIDTH-1:0]   b_edge,
  output logic                 array_nreset
);

  localparam int              TW     = $clog2(3*N-1);
  localparam logic [TW-1:0]   TLAST  = TW'(3*N-2);
  localparam logic [TW-1:0]   TFETCH = TW'(N);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_FEED  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state, state_next;
  logic [TW-1:0] t;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CLEAR;
      S_CLEAR: state_next = S_FEED;
      S_FEED:  if (t == TLAST) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // array_nreset is looked ahead from state_next so it is low exactly during CLEAR
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state        <= S_IDLE;
      t            <= '0;
      array_nreset <= 1'b0;
    end else begin
      state        <= state_next;
      t            <= (state == S_FEED && state_next == S_FEED) ? t + 1'b1 : '0;
      array_nreset <= (state_next != S_CLEAR);
    end
  end

  assign busy  = (state == S_CLEAR) || (state == S_FEED);
  assign done  = (state == S_DONE);
  assign rd_en = (state == S_FEED) && (t < TFETCH);
  assign rd_k  = rd_en ? t[KW-1:0] : '0;

  // Stage 0 is the buffer's registered output; lane i adds i further delay registers.
  // A lane i and B lane i share the same delay, so they share one valid chain.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [WIDTH-1:0] a_in, b_in, a_out, b_out;
    logic [i:0]       vld;

    assign a_in = rd_a_col[i*WIDTH +: WIDTH];
    assign b_in = rd_b_row[i*WIDTH +: WIDTH];

    if (i == 0) begin : g_direct
      assign a_out = a_in;
      assign b_out = b_in;
      always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) vld <= '0;
        else         vld <= rd_en;
      end
    end else begin : g_delay
      logic [WIDTH-1:0] a_sr [i];
      logic [WIDTH-1:0] b_sr [i];
      always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
          vld <= '0;
          for (int unsigned s = 0; s < i; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else begin
          vld     <= {vld[i-1:0], rd_en};
          a_sr[0] <= a_in;
          b_sr[0] <= b_in;
          for (int unsigned s = 1; s < i; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end
      assign a_out = a_sr[i-1];
      assign b_out = b_sr[i-1];
    end

    assign a_edge[i*WIDTH +: WIDTH] = vld[i] ? a_out : '0;
    assign b_edge[i*WIDTH +: WIDTH] = vld[i] ? b_out : '0;
  end

endmodule
